// File: rtl/seg_display_driver.sv
// ---------------------------------------------------------------------------
// seg_display_driver
//
// Display stage of the workout timer. Takes the workout phase, exercise number
// and countdown seconds from the workout controller. It converts them to BCD
// with a sequential double-dabble engine and drives a 5-digit multiplexed
// 7-segment bank. The display has leading-zero blanking, a rest indicator
// (decimal point on d3) and a blink on the last seconds.
//
// Ports:
//   clk_40MHz          in   system clock
//   rst_n              in   asynchronous, active-low reset
//   workout_state[1:0] in   00 IDLE, 01 WORK, 10 REST, 11 shown as IDLE
//   exercise_num[8:0]  in   current exercise (binary, shown saturated to 99)
//   countdown_seconds  in   remaining seconds, binary 0..255
//   SEG_DATA[7:0]      out  [7]=dp, [6:0]=g..a, polarity set by SEG_ACTIVE_HIGH
//   SEG_SEL[4:0]       out  one-hot digit select, bit4 = leftmost digit,
//                           polarity set by SEL_ACTIVE_HIGH
//   conv_busy          out  high while a BCD conversion is in flight
// ---------------------------------------------------------------------------
module seg_display_driver #(
  parameter logic SIM_SPEEDUP     = 1'b0,
  parameter logic SEG_ACTIVE_HIGH = 1'b1,
  parameter logic SEL_ACTIVE_HIGH = 1'b1,
  parameter int   SCAN_DIV        = 40000,
  parameter int   SCAN_DIV_SIM    = 4,
  parameter int   BLINK_DIV       = 10000000,
  parameter int   BLINK_DIV_SIM   = 16
) (
  input  logic       clk_40MHz,
  input  logic       rst_n,
  input  logic [1:0] workout_state,
  input  logic [8:0] exercise_num,
  input  logic [7:0] countdown_seconds,
  output logic [7:0] SEG_DATA,
  output logic [4:0] SEG_SEL,
  output logic       conv_busy
);

  localparam int SCAN_N  = SIM_SPEEDUP ? SCAN_DIV_SIM  : SCAN_DIV;
  localparam int BLINK_N = SIM_SPEEDUP ? BLINK_DIV_SIM : BLINK_DIV;
  localparam int SCAN_W  = (SCAN_N  > 1) ? $clog2(SCAN_N)  : 1;
  localparam int BLINK_W = (BLINK_N > 1) ? $clog2(BLINK_N) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_N - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_N - 1);

  // The output XOR masks are the only place where pin polarity exists.
  localparam logic [7:0] SEG_XOR = SEG_ACTIVE_HIGH ? 8'h00 : 8'hFF;
  localparam logic [4:0] SEL_XOR = SEL_ACTIVE_HIGH ? 5'h00 : 5'h1F;

  localparam logic [7:0] GLYPH_DASH  = 8'h40;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] DP_BIT      = 8'h80;

  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_WORK = 2'b01,
    PH_REST = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'b00,
    CONV_SHIFT = 2'b01,
    CONV_LOAD  = 2'b10
  } conv_state_t;

  // Adds 3 to a BCD nibble that is 5 or more. This is the adjust step of double-dabble.
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Glyph for one decimal digit, active-high, dp off.
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = 8'h3F;
      4'd1:    g = 8'h06;
      4'd2:    g = 8'h5B;
      4'd3:    g = 8'h4F;
      4'd4:    g = 8'h66;
      4'd5:    g = 8'h6D;
      4'd6:    g = 8'h7D;
      4'd7:    g = 8'h07;
      4'd8:    g = 8'h7F;
      4'd9:    g = 8'h6F;
      default: g = 8'h00;
    endcase
    return g;
  endfunction

  conv_state_t conv_state, conv_next;

  logic [18:0] snap;
  logic [18:0] src;
  logic        src_changed;
  logic [6:0]  ex_sat;
  phase_t      src_phase;

  // Working registers: {bcd digits, remaining binary bits}
  logic [19:0] sec_work;
  logic [15:0] ex_work;
  logic [19:0] sec_adj;
  logic [15:0] ex_adj;
  logic [2:0]  iter;
  phase_t      cap_phase;

  phase_t      disp_phase;
  logic [3:0]  disp_sec_h, disp_sec_t, disp_sec_o;
  logic [3:0]  disp_ex_t, disp_ex_o;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        scan_idx;
  logic              scan_guard;

  logic              secs_blank;
  logic [7:0]        digit_glyph;
  logic [7:0]        data_int;
  logic [4:0]        sel_int;

  assign src       = {workout_state, exercise_num, countdown_seconds};
  assign src_changed = (src != snap);
  assign ex_sat    = (exercise_num > 9'd99) ? 7'd99 : exercise_num[6:0];
  assign conv_busy = (conv_state != CONV_IDLE);

  // Pattern 11 collapses to IDLE here, so the display only knows three phases.
  always_comb begin
    src_phase = PH_IDLE;
    case (workout_state)
      2'b01:   src_phase = PH_WORK;
      2'b10:   src_phase = PH_REST;
      default: src_phase = PH_IDLE;
    endcase
  end

  // The adjust step runs on the current BCD nibbles. The shift happens in the register update.
  assign sec_adj = {dd_adj(sec_work[19:16]), dd_adj(sec_work[15:12]),
                    dd_adj(sec_work[11:8]), sec_work[7:0]};
  assign ex_adj  = {dd_adj(ex_work[15:12]), dd_adj(ex_work[11:8]), ex_work[7:0]};

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      conv_state <= CONV_IDLE;
    end else begin
      conv_state <= conv_next;
    end
  end

  // Capture takes one cycle, there are eight shift cycles, and the load takes one cycle.
  always_comb begin
    conv_next = conv_state;
    case (conv_state)
      CONV_IDLE:  if (src_changed) conv_next = CONV_SHIFT;
      CONV_SHIFT: if (iter == 3'd7) conv_next = CONV_LOAD;
      CONV_LOAD:  conv_next = CONV_IDLE;
      default:    conv_next = CONV_IDLE;
    endcase
  end

  // Conversion datapath. The display registers change only in CONV_LOAD.
  // A reset in the middle of a conversion therefore never shows a partial result.
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      snap       <= '0;
      sec_work   <= '0;
      ex_work    <= '0;
      iter       <= '0;
      cap_phase  <= PH_IDLE;
      disp_phase <= PH_IDLE;
      disp_sec_h <= '0;
      disp_sec_t <= '0;
      disp_sec_o <= '0;
      disp_ex_t  <= '0;
      disp_ex_o  <= '0;
    end else begin
      case (conv_state)
        CONV_IDLE: begin
          if (src_changed) begin
            snap      <= src;
            sec_work  <= {12'd0, countdown_seconds};
            ex_work   <= {8'd0, 1'b0, ex_sat};
            iter      <= '0;
            cap_phase <= src_phase;
          end
        end
        CONV_SHIFT: begin
          sec_work <= {sec_adj[18:0], 1'b0};
          ex_work  <= {ex_adj[14:0], 1'b0};
          iter     <= iter + 3'd1;
        end
        CONV_LOAD: begin
          disp_phase <= cap_phase;
          disp_sec_h <= sec_work[19:16];
          disp_sec_t <= sec_work[15:12];
          disp_sec_o <= sec_work[11:8];
          disp_ex_t  <= ex_work[15:12];
          disp_ex_o  <= ex_work[11:8];
        end
        default: ;
      endcase
    end
  end

  // Free-running blink timebase. It does not depend on what is displayed.
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Scan sequencer. Each digit is selected for SCAN_N clocks.
  // One extra all-off guard clock follows, and the index advances after it.
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt   <= '0;
      scan_idx   <= '0;
      scan_guard <= 1'b0;
    end else if (scan_guard) begin
      scan_guard <= 1'b0;
      scan_idx   <= (scan_idx == 3'd4) ? 3'd0 : scan_idx + 3'd1;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt   <= '0;
      scan_guard <= 1'b1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Glyph for the digit selected by scan_idx. The blink only blanks the seconds
  // digits, and only while 1..3 seconds are shown. Zero seconds stays steady.
  always_comb begin
    digit_glyph = GLYPH_BLANK;
    secs_blank  = 1'b0;
    if (disp_phase == PH_WORK || disp_phase == PH_REST) begin
      secs_blank = blink_phase && (disp_sec_h == 4'd0) && (disp_sec_t == 4'd0) &&
                   (disp_sec_o != 4'd0) && (disp_sec_o <= 4'd3);
      case (scan_idx)
        3'd4: digit_glyph = (disp_ex_t == 4'd0) ? GLYPH_BLANK : seg_of(disp_ex_t);
        3'd3: digit_glyph = seg_of(disp_ex_o) | ((disp_phase == PH_REST) ? DP_BIT : 8'h00);
        3'd2: digit_glyph = (secs_blank || disp_sec_h == 4'd0) ? GLYPH_BLANK
                                                                : seg_of(disp_sec_h);
        3'd1: digit_glyph = (secs_blank || (disp_sec_h == 4'd0 && disp_sec_t == 4'd0))
                            ? GLYPH_BLANK : seg_of(disp_sec_t);
        3'd0: digit_glyph = secs_blank ? GLYPH_BLANK : seg_of(disp_sec_o);
        default: digit_glyph = GLYPH_BLANK;
      endcase
    end else begin
      digit_glyph = GLYPH_DASH;
    end
  end

  assign data_int = scan_guard ? GLYPH_BLANK : digit_glyph;
  assign sel_int  = scan_guard ? 5'b00000 : (5'b00001 << scan_idx);

  // Output registers. SEG_DATA and SEG_SEL update on the same edge,
  // so a digit never briefly shows its neighbour's segments.
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      SEG_DATA <= SEG_XOR;
      SEG_SEL  <= SEL_XOR;
    end else begin
      SEG_DATA <= data_int ^ SEG_XOR;
      SEG_SEL  <= sel_int ^ SEL_XOR;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_display_driver
//
// Two copies of seg_display_driver run in simulation-speed mode. One has
// active-high pins and the other has active-low pins, and both share the same
// inputs. A behavioural model predicts SEG_SEL, SEG_DATA and conv_busy on every
// clock. The model works from the display rules: scan and blink position come
// from the cycle count, and digits come from decimal division.
// ---------------------------------------------------------------------------
module tb_seg_display_driver;

  localparam int SCAN_SIM  = 4;
  localparam int BLINK_SIM = 16;
  localparam int SLOT      = SCAN_SIM + 1;
  localparam int CONV_LAT  = 9;

  logic       clk;
  logic       rst_n;
  logic [1:0] ws;
  logic [8:0] ex;
  logic [7:0] sec;

  logic [7:0] data_a, data_b;
  logic [4:0] sel_a, sel_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  // Model state. mt counts the clock edges since reset release.
  int   mt;
  int   mPhase, mSec, mEx;
  int   snapWs, snapEx, snapSec;
  int   capPhase, capSec, capEx;
  bit   mBusy;
  int   loadAt;
  logic [7:0] expData;
  logic [4:0] expSel;
  logic       expBusy;

  seg_display_driver #(.SIM_SPEEDUP(1'b1)) dut_a (
    .clk_40MHz(clk), .rst_n(rst_n), .workout_state(ws), .exercise_num(ex),
    .countdown_seconds(sec), .SEG_DATA(data_a), .SEG_SEL(sel_a), .conv_busy(busy_a)
  );

  seg_display_driver #(.SIM_SPEEDUP(1'b1), .SEG_ACTIVE_HIGH(1'b0), .SEL_ACTIVE_HIGH(1'b0)) dut_b (
    .clk_40MHz(clk), .rst_n(rst_n), .workout_state(ws), .exercise_num(ex),
    .countdown_seconds(sec), .SEG_DATA(data_b), .SEG_SEL(sel_b), .conv_busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h cycle=%0d", tag, got, exp, mt);
    end
  endtask

  function automatic logic [7:0] segOf(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Active-high glyph for digit position k (4 = leftmost).
  function automatic logic [7:0] expGlyph(input int k, input int ph, input int s,
                                          input int e, input bit blinkOn);
    int  es;
    bit  blank;
    if (ph != 1 && ph != 2) return 8'h40;
    es    = (e > 99) ? 99 : e;
    blank = blinkOn && (s >= 1) && (s <= 3);
    case (k)
      4: return (es / 10 == 0) ? 8'h00 : segOf(es / 10);
      3: return segOf(es % 10) | ((ph == 2) ? 8'h80 : 8'h00);
      2: return (blank || s < 100) ? 8'h00 : segOf(s / 100);
      1: return (blank || s < 10) ? 8'h00 : segOf((s / 10) % 10);
      default: return blank ? 8'h00 : segOf(s % 10);
    endcase
  endfunction

  task automatic resetModel();
    mt = 0; mPhase = 0; mSec = 0; mEx = 0;
    snapWs = 0; snapEx = 0; snapSec = 0;
    capPhase = 0; capSec = 0; capEx = 0;
    mBusy = 1'b0; loadAt = 0;
    expData = 8'h00; expSel = 5'h00; expBusy = 1'b0;
  endtask

  // Called just after a rising edge. It predicts what that edge registered.
  task automatic modelEdge();
    int pos, idx;
    bit blinkOn;
    mt++;
    pos     = (mt - 1) % SLOT;
    idx     = ((mt - 1) / SLOT) % 5;
    blinkOn = (((mt - 1) / BLINK_SIM) % 2) == 1;
    if (pos == SCAN_SIM) begin
      expSel  = 5'h00;
      expData = 8'h00;
    end else begin
      expSel  = 5'(1 << idx);
      expData = expGlyph(idx, mPhase, mSec, mEx, blinkOn);
    end
    if (mBusy) begin
      if (mt == loadAt) begin
        mPhase = capPhase; mSec = capSec; mEx = capEx;
        mBusy  = 1'b0;
      end
    end else if (int'(ws) != snapWs || int'(ex) != snapEx || int'(sec) != snapSec) begin
      snapWs = int'(ws); snapEx = int'(ex); snapSec = int'(sec);
      capPhase = (ws == 2'd1 || ws == 2'd2) ? int'(ws) : 0;
      capSec   = int'(sec);
      capEx    = int'(ex);
      mBusy    = 1'b1;
      loadAt   = mt + CONV_LAT;
    end
    expBusy = mBusy;
  endtask

  task automatic step(input int n);
    logic [7:0] invData;
    logic [4:0] invSel;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      invData = ~expData;
      invSel  = ~expSel;
      checkOutput("sel",      sel_a,  expSel);
      checkOutput("data",     data_a, expData);
      checkOutput("busy",     busy_a, expBusy);
      checkOutput("sel_inv",  sel_b,  invSel);
      checkOutput("data_inv", data_b, invData);
      checkOutput("busy_inv", busy_b, expBusy);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic [8:0] e, input logic [7:0] c);
    ws  = s;
    ex  = e;
    sec = c;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_sel"},      sel_a,  32'h00);
    checkOutput({tag, "_data"},     data_a, 32'h00);
    checkOutput({tag, "_busy"},     busy_a, 32'h0);
    checkOutput({tag, "_sel_inv"},  sel_b,  32'h1F);
    checkOutput({tag, "_data_inv"}, data_b, 32'hFF);
    checkOutput({tag, "_busy_inv"}, busy_b, 32'h0);
  endtask

  // Asserts reset between clock edges, then releases it on a falling edge.
  task automatic doReset();
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("async_rst");
    @(negedge clk);
    checkResetOutputs("rst_hold");
    applyStimulus(2'd0, 9'd0, 8'd0);
    resetModel();
    rst_n = 1'b1;
  endtask

  initial begin
    int busyCount;
    resetModel();
    applyStimulus(2'd0, 9'd0, 8'd0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("por");
    @(negedge clk);
    @(negedge clk);
    checkResetOutputs("por_hold");
    rst_n = 1'b1;

    $display("[TB] idle dashes and scan order");
    step(60);

    $display("[TB] WORK ex=7 sec=125, conversion latency");
    applyStimulus(2'd1, 9'd7, 8'd125);
    busyCount = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (busy_a === 1'b1) busyCount++;
    end
    checkOutput("busy_len", busyCount, 9);
    step(40);

    $display("[TB] REST ex=142 sec=9, saturation and dp");
    applyStimulus(2'd2, 9'd142, 8'd9);
    step(40);

    $display("[TB] last-seconds blink, then zero");
    applyStimulus(2'd1, 9'd7, 8'd3);
    step(80);
    applyStimulus(2'd1, 9'd7, 8'd0);
    step(60);

    $display("[TB] input change during conversion");
    applyStimulus(2'd1, 9'd7, 8'd50);
    step(3);
    applyStimulus(2'd1, 9'd7, 8'd51);
    step(40);

    $display("[TB] reset mid-conversion and mid-scan");
    applyStimulus(2'd2, 9'd20, 8'd200);
    step(4);
    doReset();
    step(30);

    $display("[TB] randomized inputs");
    for (int n = 0; n < 150; n++) begin
      logic [1:0] rs;
      logic [8:0] re;
      logic [7:0] rc;
      rs = 2'($urandom_range(0, 3));
      re = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 120)) : 9'($urandom_range(0, 511));
      rc = ($urandom_range(0, 9) < 4) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
      applyStimulus(rs, re, rc);
      step($urandom_range(1, 25));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
